// File: rtl/uart_tx_tick.sv
// Tick-paced UART transmitter: one frame (start, DATA_BITS LSB-first, optional parity,
// STOP_BITS stop bits) per valid/ready handshake, each bit lasting one tick period.
module uart_tx_tick #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 busy,
    output logic                 done
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5
    } state_e;

    // Even parity is the XOR of the payload; odd parity is its inverse.
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] data);
        logic p;
        p = ^data;
        if (PARITY == 2) begin
            p = ~p;
        end else begin
            p = p;
        end
        return p;
    endfunction

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 par_q, par_d;
    logic                 tx_out_q, tx_out_d;
    logic                 done_q, done_d;

    // Next-state and next-output logic; every transition after the handshake waits for tick.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        par_d      = par_q;
        tx_out_d   = tx_out_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_out_d = 1'b1;
                if (tx_valid) begin
                    shift_d    = tx_data;
                    par_d      = calc_parity(tx_data);
                    bit_idx_d  = '0;
                    stop_cnt_d = 1'b0;
                    state_d    = S_ARM;
                end else begin
                    state_d = S_IDLE;
                end
            end
            // Waiting here puts the start bit on a tick boundary so it lasts a full bit time.
            S_ARM: begin
                tx_out_d = 1'b1;
                if (tick) begin
                    state_d  = S_START;
                    tx_out_d = 1'b0;
                end else begin
                    state_d = S_ARM;
                end
            end
            S_START: begin
                if (tick) begin
                    state_d   = S_DATA;
                    tx_out_d  = shift_q[0];
                    bit_idx_d = '0;
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (bit_idx_q < LAST_IDX) begin
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 1'b1;
                        tx_out_d  = shift_q[1];
                    end else if (PARITY != 0) begin
                        state_d  = S_PARITY;
                        tx_out_d = par_q;
                    end else begin
                        state_d    = S_STOP;
                        tx_out_d   = 1'b1;
                        stop_cnt_d = 1'b0;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_PARITY: begin
                if (tick) begin
                    state_d    = S_STOP;
                    tx_out_d   = 1'b1;
                    stop_cnt_d = 1'b0;
                end else begin
                    state_d = S_PARITY;
                end
            end
            S_STOP: begin
                tx_out_d = 1'b1;
                if (tick) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        state_d    = S_IDLE;
                        done_d     = 1'b1;
                        stop_cnt_d = 1'b0;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            default: begin
                state_d    = S_IDLE;
                tx_out_d   = 1'b1;
                shift_d    = '0;
                bit_idx_d  = '0;
                stop_cnt_d = 1'b0;
                par_d      = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset that abandons any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_q      <= 1'b0;
            tx_out_q   <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            par_q      <= par_d;
            tx_out_q   <= tx_out_d;
            done_q     <= done_d;
        end
    end

    assign tx_ready = (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);
    assign tx_out   = tx_out_q;
    assign done     = done_q;

endmodule

// File: tb/tb_uart_tx_tick.sv
// Directed bench for uart_tx_tick: four instances cover 8N1, 8E1, 8O1 and 8N2 framing.
module tb_uart_tx_tick;

    logic       clk;
    logic       rst;
    logic       tick;
    logic [7:0] tx_data;
    logic [3:0] valid_v;
    logic       out0, out1, out2, out3;
    logic       rdy0, rdy1, rdy2, rdy3;
    logic       busy0, busy1, busy2, busy3;
    logic       done0, done1, done2, done3;
    wire  [3:0] out_v  = {out3, out2, out1, out0};
    wire  [3:0] rdy_v  = {rdy3, rdy2, rdy1, rdy0};
    wire  [3:0] busy_v = {busy3, busy2, busy1, busy0};
    wire  [3:0] done_v = {done3, done2, done1, done0};

    int checks = 0;
    int errors = 0;

    uart_tx_tick #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n1 (
        .clk(clk), .rst(rst), .tick(tick), .tx_data(tx_data), .tx_valid(valid_v[0]),
        .tx_ready(rdy0), .tx_out(out0), .busy(busy0), .done(done0));
    uart_tx_tick #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_e1 (
        .clk(clk), .rst(rst), .tick(tick), .tx_data(tx_data), .tx_valid(valid_v[1]),
        .tx_ready(rdy1), .tx_out(out1), .busy(busy1), .done(done1));
    uart_tx_tick #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_o1 (
        .clk(clk), .rst(rst), .tick(tick), .tx_data(tx_data), .tx_valid(valid_v[2]),
        .tx_ready(rdy2), .tx_out(out2), .busy(busy2), .done(done2));
    uart_tx_tick #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_n2 (
        .clk(clk), .rst(rst), .tick(tick), .tx_data(tx_data), .tx_valid(valid_v[3]),
        .tx_ready(rdy3), .tx_out(out3), .busy(busy3), .done(done3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshake one byte on instance id, tick every 4 clocks; exp holds line levels in time order (MSB first).
    task automatic send_frame(input int id, input logic [7:0] data, input int len,
                              input logic [15:0] exp, input string name);
        tick = 1'b0;
        tx_data = data;
        valid_v[id] = 1'b1;
        @(negedge clk);
        valid_v[id] = 1'b0;
        checks++;
        if (rdy_v[id] !== 1'b0 || busy_v[id] !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: ready=%b busy=%b required ready=0 busy=1", name, rdy_v[id], busy_v[id]);
        end
        for (int k = 0; k <= 4 * len; k++) begin
            tick = (k % 4 == 0) ? 1'b1 : 1'b0;
            @(negedge clk);
            checks++;
            if (k < 4 * len) begin
                if (out_v[id] !== exp[len - 1 - k / 4] || done_v[id] !== 1'b0 || rdy_v[id] !== 1'b0) begin
                    errors++;
                    $display("FAIL %s cyc%0d: tx_out=%b done=%b ready=%b required tx_out=%b done=0 ready=0",
                             name, k, out_v[id], done_v[id], rdy_v[id], exp[len - 1 - k / 4]);
                end
            end else begin
                if (out_v[id] !== 1'b1 || done_v[id] !== 1'b1 || rdy_v[id] !== 1'b1 || busy_v[id] !== 1'b0) begin
                    errors++;
                    $display("FAIL %s end: tx_out=%b done=%b ready=%b busy=%b required 1 1 1 0",
                             name, out_v[id], done_v[id], rdy_v[id], busy_v[id]);
                end
            end
        end
        tick = 1'b0;
        @(negedge clk);
        checks++;
        if (done_v[id] !== 1'b0 || out_v[id] !== 1'b1 || rdy_v[id] !== 1'b1) begin
            errors++;
            $display("FAIL %s after: done=%b tx_out=%b ready=%b required 0 1 1", name, done_v[id], out_v[id], rdy_v[id]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick = 1'b1;
        tx_data = 8'hFF;
        valid_v = 4'hF;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_v !== 4'hF || rdy_v !== 4'hF || busy_v !== 4'h0 || done_v !== 4'h0) begin
            errors++;
            $display("FAIL reset: tx_out=%b ready=%b busy=%b done=%b required 1111 1111 0000 0000",
                     out_v, rdy_v, busy_v, done_v);
        end
        rst = 1'b0;
        tick = 1'b0;
        valid_v = 4'h0;
        @(negedge clk);
        checks++;
        if (out_v !== 4'hF || rdy_v !== 4'hF || busy_v !== 4'h0 || done_v !== 4'h0) begin
            errors++;
            $display("FAIL post_reset: tx_out=%b ready=%b busy=%b done=%b required 1111 1111 0000 0000",
                     out_v, rdy_v, busy_v, done_v);
        end
    endtask

    task automatic test_8n1();
        send_frame(0, 8'hA5, 10, 16'b0101001011, "8n1_a5");
    endtask

    task automatic test_parity();
        send_frame(1, 8'hA5, 11, 16'b01010010101, "even_a5");
        send_frame(2, 8'hA5, 11, 16'b01010010111, "odd_a5");
        send_frame(1, 8'h07, 11, 16'b01110000011, "even_07");
        send_frame(2, 8'h07, 11, 16'b01110000001, "odd_07");
    endtask

    task automatic test_two_stop();
        send_frame(3, 8'h00, 11, 16'b00000000011, "8n2_00");
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        logic [9:0] frames [3];
        int   acc;
        logic hs;
        logic exp_out;
        logic exp_flag;
        bytes  = '{8'h11, 8'h22, 8'h33};
        frames = '{10'b0100010001, 10'b0010001001, 10'b0110011001};
        tick = 1'b0;
        tx_data = bytes[0];
        valid_v[0] = 1'b1;
        @(negedge clk);
        acc = 1;
        tx_data = bytes[1];
        for (int k = 0; k <= 128; k++) begin
            hs = rdy_v[0] & valid_v[0];
            tick = (k % 4 == 0) ? 1'b1 : 1'b0;
            @(negedge clk);
            if (hs) begin
                acc++;
                if (acc < 3) begin
                    tx_data = bytes[acc];
                end else begin
                    valid_v[0] = 1'b0;
                end
            end
            exp_out  = ((k % 44) < 40) ? frames[k / 44][9 - (k % 44) / 4] : 1'b1;
            exp_flag = ((k % 44) == 40) ? 1'b1 : 1'b0;
            checks++;
            if (out_v[0] !== exp_out || done_v[0] !== exp_flag || rdy_v[0] !== exp_flag) begin
                errors++;
                $display("FAIL b2b cyc%0d: tx_out=%b done=%b ready=%b required tx_out=%b done=%b ready=%b",
                         k, out_v[0], done_v[0], rdy_v[0], exp_out, exp_flag, exp_flag);
            end
        end
        tick = 1'b0;
        @(negedge clk);
        checks++;
        if (acc != 3 || rdy_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || out_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL b2b end: accepted=%0d ready=%b busy=%b tx_out=%b required 3 1 0 1",
                     acc, rdy_v[0], busy_v[0], out_v[0]);
        end
    endtask

    task automatic test_reset_mid_frame();
        tick = 1'b0;
        tx_data = 8'hA5;
        valid_v[0] = 1'b1;
        @(negedge clk);
        valid_v[0] = 1'b0;
        for (int k = 0; k <= 21; k++) begin
            tick = (k % 4 == 0) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        checks++;
        if (out_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_bit4: tx_out=%b busy=%b required 0 1", out_v[0], busy_v[0]);
        end
        rst = 1'b1;
        tick = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (out_v[0] !== 1'b1 || rdy_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst: tx_out=%b ready=%b busy=%b done=%b required 1 1 0 0",
                     out_v[0], rdy_v[0], busy_v[0], done_v[0]);
        end
        for (int k = 0; k < 16; k++) begin
            tick = (k % 4 == 0) ? 1'b1 : 1'b0;
            @(negedge clk);
            checks++;
            if (out_v[0] !== 1'b1 || done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
                errors++;
                $display("FAIL rst_idle cyc%0d: tx_out=%b done=%b busy=%b required 1 0 0",
                         k, out_v[0], done_v[0], busy_v[0]);
            end
        end
        send_frame(0, 8'h3C, 10, 16'b0001111001, "after_rst_3c");
    endtask

    task automatic test_tick_edges();
        logic [12:0] tk_pat;
        logic [12:0] out_pat;
        logic [12:0] done_pat;
        tk_pat   = 13'b1110011111111;
        out_pat  = 13'b0100010010111;
        done_pat = 13'b0000000000001;
        tx_data = 8'hA5;
        valid_v[0] = 1'b1;
        tick = 1'b1;
        @(negedge clk);
        valid_v[0] = 1'b0;
        tick = 1'b0;
        checks++;
        if (out_v[0] !== 1'b1 || busy_v[0] !== 1'b1 || rdy_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL tick_hs: tx_out=%b busy=%b ready=%b required 1 1 0", out_v[0], busy_v[0], rdy_v[0]);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (out_v[0] !== 1'b1 || busy_v[0] !== 1'b1) begin
                errors++;
                $display("FAIL tick_arm cyc%0d: tx_out=%b busy=%b required 1 1", k, out_v[0], busy_v[0]);
            end
        end
        for (int k = 0; k < 13; k++) begin
            tick = tk_pat[12 - k];
            @(negedge clk);
            checks++;
            if (out_v[0] !== out_pat[12 - k] || done_v[0] !== done_pat[12 - k]) begin
                errors++;
                $display("FAIL tick_run cyc%0d: tx_out=%b done=%b required tx_out=%b done=%b",
                         k, out_v[0], done_v[0], out_pat[12 - k], done_pat[12 - k]);
            end
        end
        tick = 1'b0;
        @(negedge clk);
        checks++;
        if (done_v[0] !== 1'b0 || rdy_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL tick_end: done=%b ready=%b required 0 1", done_v[0], rdy_v[0]);
        end
    endtask

    initial begin
        rst = 1'b1;
        tick = 1'b0;
        tx_data = 8'h00;
        valid_v = 4'h0;
        test_reset();
        test_8n1();
        test_parity();
        test_two_stop();
        test_back_to_back();
        test_reset_mid_frame();
        test_tick_edges();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
